// File: rtl/seg7_scan_if.sv
// Bundles the user-facing controls and the display-pin outputs of the
// multiplexed 7-segment scan driver. The master side is the user logic,
// the slave side is the driver itself.
interface seg7_scan_if #(
    parameter int DIGITS = 4
);
    logic                  load;
    logic [4*DIGITS-1:0]   value;
    logic [DIGITS-1:0]     dp_in;
    logic                  hex_en;
    logic                  lz_en;
    logic                  blank_n;
    logic [6:0]            segments;
    logic                  dp;
    logic [DIGITS-1:0]     digit_en;
    logic                  frame_start;

    modport master (
        output load, value, dp_in, hex_en, lz_en, blank_n,
        input  segments, dp, digit_en, frame_start
    );

    modport slave (
        input  load, value, dp_in, hex_en, lz_en, blank_n,
        output segments, dp, digit_en, frame_start
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// N-digit multiplexed 7-segment display driver.
// A prescaler divides each digit slot into PRESCALE clocks; the last clock of
// every slot is dead time with all digit enables off to prevent ghosting.
// The displayed value is double buffered: loads land in a pending register and
// are promoted to the active register only at a frame boundary, so a frame
// never shows a mix of old and new digits. All outputs are registered one
// cycle behind the (pre, idx) counter state; polarity inversion happens only
// in the output registers.
module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int PRESCALE       = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b0,
    parameter bit DIG_ACTIVE_LOW = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    seg7_scan_if.slave  bus
);

    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_MASK = {7{SEG_ACTIVE_LOW}};
    localparam logic [DIGITS-1:0] DIG_MASK = {DIGITS{DIG_ACTIVE_LOW}};

    // Scan counters
    logic [PRE_W-1:0] pre_reg;
    logic [IDX_W-1:0] idx_reg;
    logic             pre_wrap;
    logic             frame_end;

    // Display buffers
    logic [4*DIGITS-1:0] active_value_reg;
    logic [DIGITS-1:0]   active_dp_reg;
    logic [4*DIGITS-1:0] pending_value_reg;
    logic [DIGITS-1:0]   pending_dp_reg;
    logic                pending_vld_reg;

    // Output stage
    logic [6:0]        segments_reg;
    logic              dp_reg;
    logic [DIGITS-1:0] digit_en_reg;
    logic              frame_start_reg;

    logic [6:0]        segments_next;
    logic              dp_next;
    logic [DIGITS-1:0] digit_en_next;
    logic              frame_start_next;

    logic [3:0]        cur_nib;
    logic              cur_dp;
    logic              cur_lz;
    logic [DIGITS-1:0] digit_onehot;
    logic [DIGITS-1:0] lz_blank;

    assign pre_wrap  = (pre_reg == PRE_LAST);
    assign frame_end = pre_wrap && (idx_reg == IDX_LAST);

    // Glyph table, segment order {g,f,e,d,c,b,a}; BCD mode blanks 10..15
    function automatic logic [6:0] glyph(input logic [3:0] nib, input logic hex);
        logic [6:0] g;
        case (nib)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h71;
        endcase
        if (!hex && (nib > 4'd9)) begin
            g = 7'h00;
        end
        return g;
    endfunction

    // Leading-zero mask: digit n is blank when it and every more significant
    // nibble are zero; digit 0 always shows so a zero value still reads "0"
    assign lz_blank[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < DIGITS; gi++) begin : g_lz
            assign lz_blank[gi] = (active_value_reg[4*DIGITS-1:4*gi] == '0);
        end
    endgenerate

    // Prescaler and digit index; idx advances on every slot wrap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_reg <= '0;
            idx_reg <= '0;
        end else if (pre_wrap) begin
            pre_reg <= '0;
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end else begin
            pre_reg <= pre_reg + 1'b1;
        end
    end

    // Double buffer: a load coinciding with the frame boundary goes straight
    // to the active register, otherwise it waits in pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_value_reg  <= '0;
            active_dp_reg     <= '0;
            pending_value_reg <= '0;
            pending_dp_reg    <= '0;
            pending_vld_reg   <= 1'b0;
        end else if (frame_end) begin
            pending_vld_reg <= 1'b0;
            if (bus.load) begin
                active_value_reg <= bus.value;
                active_dp_reg    <= bus.dp_in;
            end else if (pending_vld_reg) begin
                active_value_reg <= pending_value_reg;
                active_dp_reg    <= pending_dp_reg;
            end
        end else if (bus.load) begin
            pending_value_reg <= bus.value;
            pending_dp_reg    <= bus.dp_in;
            pending_vld_reg   <= 1'b1;
        end
    end

    // Select the nibble, dp and lz flag of the digit currently being scanned
    always_comb begin
        cur_nib      = '0;
        cur_dp       = 1'b0;
        cur_lz       = 1'b0;
        digit_onehot = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_reg == IDX_W'(i)) begin
                cur_nib         = active_value_reg[4*i +: 4];
                cur_dp          = active_dp_reg[i];
                cur_lz          = lz_blank[i];
                digit_onehot[i] = 1'b1;
            end
        end
    end

    // Active-high output values for the next edge
    always_comb begin
        segments_next    = '0;
        dp_next          = 1'b0;
        digit_en_next    = '0;
        frame_start_next = 1'b0;
        if (bus.blank_n) begin
            dp_next = cur_dp;
            if (!(bus.lz_en && cur_lz)) begin
                segments_next = glyph(cur_nib, bus.hex_en);
            end
        end
        if (!pre_wrap) begin
            digit_en_next = digit_onehot;
        end
        frame_start_next = (pre_reg == '0) && (idx_reg == '0);
    end

    // Output registers; polarity applied here, reset to the inactive level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments_reg    <= SEG_MASK;
            dp_reg          <= SEG_ACTIVE_LOW;
            digit_en_reg    <= DIG_MASK;
            frame_start_reg <= 1'b0;
        end else begin
            segments_reg    <= segments_next ^ SEG_MASK;
            dp_reg          <= dp_next ^ SEG_ACTIVE_LOW;
            digit_en_reg    <= digit_en_next ^ DIG_MASK;
            frame_start_reg <= frame_start_next;
        end
    end

    assign bus.segments    = segments_reg;
    assign bus.dp          = dp_reg;
    assign bus.digit_en    = digit_en_reg;
    assign bus.frame_start = frame_start_reg;

endmodule
